// File: rtl/imem_ctrl.sv
// Instruction memory controller: single-cycle fetch port with registered response,
// plus a loader port that writes the array while fetching is paused.
module imem_ctrl #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       DEPTH    = 64,
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013,
   localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_err,
   input  logic              prog_en,
   input  logic              prog_we,
   input  logic [IDX_W-1:0]  prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic              prog_active
);

   localparam logic [1:0] StRun   = 2'd0;
   localparam logic [1:0] StDrain = 2'd1;
   localparam logic [1:0] StProg  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [1:0]        rsp_err_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              req_fire;
   logic              mem_we;
   logic              misaligned;
   logic              out_of_range;
   logic [IDX_W-1:0]  word_idx;
   logic [ADDR_W+31:0] word_addr;
   logic [DATA_W-1:0] fetch_word;

   // Widened so the range check cannot wrap for any ADDR_W.
   assign word_addr    = {32'd0, req_addr} >> 2;
   assign out_of_range = word_addr >= (ADDR_W+32)'(DEPTH);
   assign misaligned   = req_addr[1:0] != 2'b00;
   assign word_idx     = req_addr[IDX_W+1:2];
   assign fetch_word   = (misaligned || out_of_range) ? NOP_WORD : mem[word_idx];

   assign req_ready = (state_q == StRun) & ~prog_en & (~rsp_valid_q | rsp_ready);
   assign req_fire  = req_valid & req_ready;
   // Writes only happen in PROG, where req_ready is low, so fetch and write never collide.
   assign mem_we    = (state_q == StProg) & prog_we & (32'(prog_addr) < DEPTH);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun: begin
            if (prog_en) state_d = (!rsp_valid_q || rsp_ready) ? StProg : StDrain;
         end
         StDrain: begin
            if (!prog_en)      state_d = StRun;
            else if (rsp_ready) state_d = StProg;
         end
         StProg: begin
            if (!prog_en) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         if (req_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= fetch_word;
            rsp_err_q   <= {out_of_range, misaligned};
         end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   // No reset on the array: contents survive rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) mem[prog_addr] <= prog_data;
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign prog_active = (state_q == StProg);

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: number of instruction words stored.
REQ-003 SHALL have parameter ADDR_W, default 32: fetch byte-address width.
REQ-004 SHALL have parameter NOP_WORD, default 32'h00000013: word returned on a faulted fetch.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  1  fetch request present.
REQ-008 SHALL have port req_ready  out  1  fetch request accepted this cycle when high with req_valid.
REQ-009 SHALL have port req_addr  in  ADDR_W  fetch byte address.
REQ-010 SHALL have port rsp_valid  out  1  response held in output register.
REQ-011 SHALL have port rsp_ready  in  1  consumer takes response this cycle.
REQ-012 SHALL have port rsp_data  out  DATA_W  fetched instruction word.
REQ-013 SHALL have port rsp_err  out  2  bit0 misaligned, bit1 out-of-range; qualified by rsp_valid.
REQ-014 SHALL have port prog_en  in  1  loader requests programming mode.
REQ-015 SHALL have port prog_we  in  1  write strobe, honoured only in PROG state.
REQ-016 SHALL have port prog_addr  in  clog2(DEPTH)  word index to write.
REQ-017 SHALL have port prog_data  in  DATA_W  word to write.
REQ-018 SHALL have port prog_active  out  1  high exactly while in PROG state.

Function
REQ-019 SHALL implement states RUN, DRAIN, PROG.
REQ-020 SHALL transition RUN->PROG when prog_en=1 and no response is pending (rsp_valid=0, or rsp_valid=1 with rsp_ready=1 that cycle).
REQ-021 SHALL transition RUN->DRAIN when prog_en=1 and a response stays pending; DRAIN->PROG on the cycle that response is taken.
REQ-022 SHALL transition PROG->RUN when prog_en=0; DRAIN->RUN if prog_en drops before the drain completes.
REQ-023 SHALL drive req_ready = (state==RUN) & ~prog_en & (~rsp_valid | rsp_ready), combinationally.
REQ-024 SHALL, on an accepted request, present rsp_valid=1 with data on the next cycle (latency 1), sustaining one fetch per cycle under rsp_ready=1.
REQ-025 SHALL hold rsp_valid, rsp_data and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-026 SHALL clear rsp_valid on rsp_ready=1 unless a new request is accepted in the same cycle.
REQ-027 SHALL index memory by req_addr[clog2(DEPTH)+1:2].
REQ-028 SHALL set rsp_err[0] when req_addr[1:0]!=0.
REQ-029 SHALL set rsp_err[1] when req_addr>>2 >= DEPTH, with no wrap-around.
REQ-030 SHALL return rsp_data=NOP_WORD when either rsp_err bit is set.
REQ-031 SHALL write prog_data to memory[prog_addr] when state==PROG and prog_we=1; prog_we in other states SHALL be ignored.
REQ-032 SHALL ignore prog_we when prog_addr >= DEPTH (non-power-of-two DEPTH).
REQ-033 SHALL never accept a fetch in the same cycle as a memory write.

Reset
REQ-034 SHALL, while rst_n=0, force state=RUN, rsp_valid=0, rsp_data=0, rsp_err=0, prog_active=0.
REQ-035 SHALL preserve memory contents through reset.
REQ-036 SHALL, when reset asserts mid-DRAIN or mid-PROG, discard the pending response or write sequence and resume in RUN after release.

Verification
REQ-037 Program words 0..3 = 0x00FF0FF0, 0x12FC123A, 0xAA22CC33, 0x00880988, drop prog_en, fetch addr 0x8 -> one cycle later rsp_valid=1, rsp_data=0xAA22CC33, rsp_err=0.
REQ-038 Back-to-back fetches 0x0, 0x4, 0xC with rsp_ready=1 -> responses on consecutive cycles: 0x00FF0FF0, 0x12FC123A, 0x00880988.
REQ-039 Fetch 0x6 -> rsp_err=2'b01, rsp_data=0x00000013; fetch 0x100 with DEPTH=64 -> rsp_err=2'b10, rsp_data=0x00000013.
REQ-040 Response pending with rsp_ready=0 for 3 cycles, then prog_en=1 -> state DRAIN, rsp_data unchanged, req_ready=0; rsp_ready=1 -> PROG next cycle, prog_active=1.
REQ-041 In PROG, write word 45 = 0xBBBBBBBB, pulse rst_n low, release -> prog_active=0, rsp_valid=0; fetch 0xB4 returns 0xBBBBBBBB.
REQ-042 prog_we=1 in RUN with prog_addr=2, data 0xDEADBEEF -> fetch 0x8 still returns 0xAA22CC33.
